// File: rtl/rl_pair_scheduler_if.sv
// Request/address/status bundle between a pass controller and the pair scheduler.
// The slave modport is the scheduler side; the master modport is the controller side.
interface rl_pair_scheduler_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] home_last;
    logic [ADDR_WIDTH-1:0] nbr_last;
    logic                  stall;
    logic                  force_valid;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] home_rdaddr;
    logic [ADDR_WIDTH-1:0] neighbor_rdaddr;
    logic                  r2_enable;
    logic                  busy;
    logic                  done;

    modport master (
        output start, home_last, nbr_last, stall, force_valid,
        input  rden, home_rdaddr, neighbor_rdaddr, r2_enable, busy, done
    );

    modport slave (
        input  start, home_last, nbr_last, stall, force_valid,
        output rden, home_rdaddr, neighbor_rdaddr, r2_enable, busy, done
    );
endinterface

// File: rtl/rl_pair_scheduler.sv
// Walks every (home, neighbor) BRAM address pair of a pass, neighbor-fastest,
// then waits until every issued pair has been retired before pulsing done.
module rl_pair_scheduler #(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 2*ADDR_WIDTH+1
) (
    input  logic                 clk,
    input  logic                 rst,
    rl_pair_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] home_lim_q, home_lim_d;
    logic [ADDR_WIDTH-1:0] nbr_lim_q, nbr_lim_d;
    logic [ADDR_WIDTH-1:0] home_ptr_q, home_ptr_d;
    logic [ADDR_WIDTH-1:0] nbr_ptr_q, nbr_ptr_d;
    logic [ADDR_WIDTH-1:0] home_addr_q, home_addr_d;
    logic [ADDR_WIDTH-1:0] nbr_addr_q, nbr_addr_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  rden_q, rden_d;
    logic                  r2_q, r2_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  issue_fire;
    logic                  last_pair;
    logic [ADDR_WIDTH-1:0] cur_home, cur_nbr;
    logic [ADDR_WIDTH-1:0] cur_home_lim, cur_nbr_lim;

    always_comb begin
        state_d      = state_q;
        home_lim_d   = home_lim_q;
        nbr_lim_d    = nbr_lim_q;
        home_ptr_d   = home_ptr_q;
        nbr_ptr_d    = nbr_ptr_q;
        home_addr_d  = home_addr_q;
        nbr_addr_d   = nbr_addr_q;
        issued_d     = issued_q;
        retired_d    = retired_q;
        rden_d       = 1'b0;
        r2_d         = rden_q;
        issue_fire   = 1'b0;
        last_pair    = 1'b0;
        cur_home     = home_ptr_q;
        cur_nbr      = nbr_ptr_q;
        cur_home_lim = home_lim_q;
        cur_nbr_lim  = nbr_lim_q;

        // The accepting edge itself issues pair (0,0), so rden rises the cycle after start.
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    home_lim_d   = bus.home_last;
                    nbr_lim_d    = bus.nbr_last;
                    issued_d     = '0;
                    retired_d    = '0;
                    cur_home     = '0;
                    cur_nbr      = '0;
                    cur_home_lim = bus.home_last;
                    cur_nbr_lim  = bus.nbr_last;
                    issue_fire   = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                issue_fire = !bus.stall;
            end
            DRAIN: begin
                if (retired_q == issued_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && bus.force_valid) begin
            retired_d = retired_q + CNT_ONE;
        end

        last_pair = (cur_home == cur_home_lim) && (cur_nbr == cur_nbr_lim);

        if (issue_fire) begin
            rden_d      = 1'b1;
            home_addr_d = cur_home;
            nbr_addr_d  = cur_nbr;
            issued_d    = issued_d + CNT_ONE;
            if (cur_nbr == cur_nbr_lim) begin
                nbr_ptr_d  = '0;
                home_ptr_d = cur_home + ADDR_ONE;
            end else begin
                nbr_ptr_d  = cur_nbr + ADDR_ONE;
                home_ptr_d = cur_home;
            end
            if (last_pair) begin
                state_d = DRAIN;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            home_lim_q  <= '0;
            nbr_lim_q   <= '0;
            home_ptr_q  <= '0;
            nbr_ptr_q   <= '0;
            home_addr_q <= '0;
            nbr_addr_q  <= '0;
            issued_q    <= '0;
            retired_q   <= '0;
            rden_q      <= 1'b0;
            r2_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            home_lim_q  <= home_lim_d;
            nbr_lim_q   <= nbr_lim_d;
            home_ptr_q  <= home_ptr_d;
            nbr_ptr_q   <= nbr_ptr_d;
            home_addr_q <= home_addr_d;
            nbr_addr_q  <= nbr_addr_d;
            issued_q    <= issued_d;
            retired_q   <= retired_d;
            rden_q      <= rden_d;
            r2_q        <= r2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rden            = rden_q;
    assign bus.home_rdaddr     = home_addr_q;
    assign bus.neighbor_rdaddr = nbr_addr_q;
    assign bus.r2_enable       = r2_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;

endmodule

// File: tb/tb_rl_pair_scheduler.sv
// Randomized bench for rl_pair_scheduler against a pair-count/arithmetic reference model.
module tb_rl_pair_scheduler;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;

    rl_pair_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

    rl_pair_scheduler #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: a pass is P = (h+1)*(n+1) pairs; pair k = (k / (n+1), k % (n+1)).
    bit m_busy, m_done;
    int m_total, m_issued, m_retired, m_nl1;
    bit exp_rden, exp_r2;
    int exp_h, exp_n;
    int obs_rden, obs_done;
    int ret_q[$];

    task automatic model_step(input bit r, input bit s, input int hl, input int nl,
                              input bit st, input bit fv);
        bit prev_rden;
        prev_rden = exp_rden;
        if (r) begin
            m_busy = 0; m_done = 0; m_total = 0; m_issued = 0; m_retired = 0;
            exp_rden = 0; exp_r2 = 0; exp_h = 0; exp_n = 0;
            return;
        end
        exp_r2   = prev_rden;
        exp_rden = 0;
        if (!m_busy) begin
            if (s) begin
                m_busy    = 1;
                m_done    = 0;
                m_nl1     = nl + 1;
                m_total   = (hl + 1) * (nl + 1);
                m_issued  = 1;
                m_retired = 0;
                exp_rden  = 1;
                exp_h     = 0;
                exp_n     = 0;
            end
        end else if (m_done) begin
            m_busy = 0;
            m_done = 0;
        end else begin
            if (m_issued < m_total) begin
                if (!st) begin
                    exp_h    = m_issued / m_nl1;
                    exp_n    = m_issued % m_nl1;
                    exp_rden = 1;
                    m_issued++;
                end
            end else if (m_retired == m_total) begin
                m_done = 1;
            end
            if (fv) m_retired++;
        end
    endtask

    task automatic tick(input bit r, input bit s, input int hl, input int nl,
                        input bit st, input bit fv);
        logic [31:0] hv, nv;
        hv = hl;
        nv = nl;
        rst             = r;
        bus.start       = s;
        bus.home_last   = hv[AW-1:0];
        bus.nbr_last    = nv[AW-1:0];
        bus.stall       = st;
        bus.force_valid = fv;
        @(posedge clk);
        model_step(r, s, hl, nl, st, fv);
        #1;
        check("rden", 64'(bus.rden), 64'(exp_rden));
        check("r2_enable", 64'(bus.r2_enable), 64'(exp_r2));
        check("home_rdaddr", 64'(bus.home_rdaddr), 64'(exp_h));
        check("neighbor_rdaddr", 64'(bus.neighbor_rdaddr), 64'(exp_n));
        check("busy", 64'(bus.busy), 64'(m_busy));
        check("done", 64'(bus.done), 64'(m_done));
        if (bus.rden === 1'b1) obs_rden++;
        if (bus.done === 1'b1) obs_done++;
    endtask

    // One pass: forced stall window [stall_lo, stall_hi] (cycle 0 = start cycle),
    // retirements returned dly..dly+jit cycles after each rden, at most max_ret of them.
    task automatic run_pass(input int hl, input int nl, input int stall_lo, input int stall_hi,
                            input int stall_pct, input int dly, input int jit, input int max_ret,
                            input int abort_n, input bit noise, input int max_cyc,
                            input bit expect_done);
        int  scheduled, last_at, t;
        bit  finished, aborted, st, fv, s, r;
        scheduled = 0;
        last_at   = 0;
        finished  = 0;
        aborted   = 0;
        ret_q.delete();
        obs_rden = 0;
        obs_done = 0;
        tick(0, 1, hl, nl, 1'($urandom_range(1)), 0);
        if (exp_rden && scheduled < max_ret) begin
            last_at = 1 + dly + int'($urandom_range(jit));
            ret_q.push_back(last_at);
            scheduled++;
        end
        for (int c = 1; c < max_cyc && !finished; c++) begin
            st = ((c >= stall_lo) && (c <= stall_hi)) || (int'($urandom_range(99)) < stall_pct);
            fv = 0;
            if (ret_q.size() > 0 && ret_q[0] <= c) begin
                fv = 1;
                void'(ret_q.pop_front());
            end
            s = noise && ($urandom_range(7) == 0);
            r = (abort_n > 0) && (m_issued == abort_n);
            tick(r, s, s ? int'($urandom_range(63)) : hl, s ? int'($urandom_range(63)) : nl, st, fv);
            if (exp_rden && scheduled < max_ret) begin
                t = c + 1 + dly + int'($urandom_range(jit));
                if (t < last_at) t = last_at;
                last_at = t;
                ret_q.push_back(t);
                scheduled++;
            end
            if (r) begin
                finished = 1;
                aborted  = 1;
            end else if (!m_busy) begin
                finished = 1;
            end
        end
        if (aborted) begin
            check("abort_rden_count", 64'(obs_rden), 64'(abort_n));
            check("abort_no_done", 64'(obs_done), 64'd0);
        end else begin
            if (expect_done) check("pass_finished", 64'(finished), 64'd1);
            check("pass_rden_count", 64'(obs_rden), 64'((hl + 1) * (nl + 1)));
            check("pass_done_count", 64'(obs_done), expect_done ? 64'd1 : 64'd0);
        end
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++) begin
            tick(0, 0, 0, 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
    endtask

    initial begin
        exp_rden = 0; exp_r2 = 0; exp_h = 0; exp_n = 0;
        m_busy = 0; m_done = 0; m_total = 0; m_issued = 0; m_retired = 0; m_nl1 = 1;
        obs_rden = 0; obs_done = 0;

        tick(1, 0, 0, 0, 0, 0);
        tick(1, 1, 5, 5, 1, 1);
        idle_noise(3);

        // Basic pass, then stall window in cycles 2..3.
        run_pass(1, 2, -1, -1, 0, 2, 0, 1000, 0, 0, 100, 1);
        idle_noise(2);
        run_pass(1, 2, 2, 3, 0, 1, 0, 1000, 0, 0, 100, 1);
        idle_noise(2);

        // Single pair, retirement 5 cycles after rden.
        run_pass(0, 0, -1, -1, 0, 5, 0, 1000, 0, 0, 100, 1);
        idle_noise(2);

        // One retirement withheld: pass never completes, then reset recovers.
        run_pass(1, 2, -1, -1, 0, 1, 0, 5, 0, 0, 60, 0);
        tick(1, 0, 0, 0, 0, 0);

        // Reset after 3 pairs, then a fresh 2-pair pass.
        run_pass(3, 3, -1, -1, 0, 2, 0, 1000, 3, 0, 100, 0);
        run_pass(0, 1, -1, -1, 0, 0, 0, 1000, 0, 0, 100, 1);
        idle_noise(2);

        // Start pulses while busy must be ignored.
        run_pass(2, 3, -1, -1, 20, 3, 2, 1000, 0, 1, 300, 1);
        idle_noise(2);

        // All-ones limits exercise both wraps and the counter width.
        run_pass(63, 63, -1, -1, 10, 2, 3, 100000, 0, 1, 20000, 1);
        idle_noise(2);

        for (int p = 0; p < 40; p++) begin
            run_pass(int'($urandom_range(7)), int'($urandom_range(7)), -1, -1,
                     int'($urandom_range(50)), int'($urandom_range(6)), int'($urandom_range(3)),
                     1000, 0, 1'($urandom_range(1)), 2000, 1);
            idle_noise(int'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
